// File: rtl/scr1_ahb_dmem_sram.sv
// AHB-Lite single-port SRAM slave for the data-memory bridge.
// Handles byte/halfword/word transfers with a fixed number of wait states.
// Out-of-range, misaligned and illegal-size accesses get the two-cycle ERROR response.
module scr1_ahb_dmem_sram #(
    parameter int unsigned MEM_WORDS   = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hsel,
    input  logic [1:0]  htrans,
    input  logic [31:0] haddr,
    input  logic [2:0]  hsize,
    input  logic        hwrite,
    input  logic [31:0] hwdata,
    input  logic [3:0]  hprot,
    input  logic [2:0]  hburst,
    input  logic        hmastlock,
    output logic        hready,
    output logic        hresp,
    output logic [31:0] hrdata
);

    localparam int unsigned IDX_W         = $clog2(MEM_WORDS);
    localparam logic [32:0] SPAN          = 33'(MEM_WORDS) << 2;
    localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;

    typedef enum logic [2:0] {StIdle, StWait, StData, StErr1, StErr2} state_e;

    state_e             r_state;
    state_e             w_state_nxt;
    logic [3:0]         r_cnt;
    logic [3:0]         w_cnt_nxt;
    logic [31:0]        r_a_addr;
    logic [2:0]         r_a_size;
    logic               r_a_write;
    logic               w_accept;
    logic               w_err;
    logic [32:0]        w_off;
    logic [31:0]        w_a_off;
    logic [IDX_W-1:0]   w_idx;
    logic [3:0]         w_be;
    logic               w_unused;
    logic [31:0]        r_mem [MEM_WORDS];

    // Sideband attributes carry nothing this slave needs.
    assign w_unused = ^{hprot, hburst, hmastlock, w_a_off};

    assign hready   = !(r_state == StWait || r_state == StErr1);
    assign hresp    = (r_state == StErr1) || (r_state == StErr2);
    assign w_accept = hsel && (htrans == HTRANS_NONSEQ) && hready;

    // Offset computed in 33 bits so addresses below the base wrap into bit 32.
    assign w_off = {1'b0, haddr} - {1'b0, BASE_ADDR};

    // Error classification of the address phase being offered.
    always_comb begin
        w_err = w_off[32] || (w_off >= SPAN);
        case (hsize)
            3'd0:    ;
            3'd1:    if (haddr[0]) w_err = 1'b1;
            3'd2:    if (haddr[1:0] != 2'b00) w_err = 1'b1;
            default: w_err = 1'b1;
        endcase
    end

    assign w_a_off = r_a_addr - BASE_ADDR;
    assign w_idx   = w_a_off[IDX_W+1:2];

    // Byte-lane enables for the captured transfer.
    always_comb begin
        w_be = 4'b0000;
        case (r_a_size)
            3'd0:    w_be = 4'b0001 << r_a_addr[1:0];
            3'd1:    w_be = r_a_addr[1] ? 4'b1100 : 4'b0011;
            3'd2:    w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    // State, wait counter and address-phase capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_cnt     <= 4'd0;
            r_a_addr  <= 32'd0;
            r_a_size  <= 3'd0;
            r_a_write <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_a_addr  <= haddr;
                r_a_size  <= hsize;
                r_a_write <= hwrite;
            end
        end
    end

    // Next-state logic; IDLE, DATA and ERR2 can all take a new address phase.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            StIdle, StData, StErr2: begin
                if (!w_accept) begin
                    w_state_nxt = StIdle;
                end else if (w_err) begin
                    w_state_nxt = StErr1;
                end else if (WAIT_STATES == 0) begin
                    w_state_nxt = StData;
                end else begin
                    w_state_nxt = StWait;
                    w_cnt_nxt   = 4'(WAIT_STATES);
                end
            end
            StWait: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt <= 4'd1) w_state_nxt = StData;
            end
            StErr1: w_state_nxt = StErr2;
            default: begin
                w_state_nxt = StIdle;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Write commit at the edge that ends DATA; memory is never reset.
    always_ff @(posedge clk) begin
        if (r_state == StData && r_a_write) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[w_idx][8*b +: 8] <= hwdata[8*b +: 8];
            end
        end
    end

    // Full word on a read data phase, zero otherwise.
    always_comb begin
        hrdata = 32'd0;
        if (r_state == StData && !r_a_write) hrdata = r_mem[w_idx];
    end

endmodule

// File: tb/tb_scr1_ahb_dmem_sram.sv
module tb_scr1_ahb_dmem_sram;

    localparam logic [31:0] BASE  = 32'h0001_0000;
    localparam int unsigned WORDS = 64;

    logic        clk;
    logic        rst_n;
    logic        hsel0;
    logic        hsel1;
    logic [1:0]  htrans;
    logic [31:0] haddr;
    logic [2:0]  hsize;
    logic        hwrite;
    logic [31:0] hwdata;
    logic [3:0]  hprot;
    logic [2:0]  hburst;
    logic        hmastlock;
    logic        hready1;
    logic        hresp1;
    logic [31:0] hrdata1;
    logic        hready0;
    logic        hresp0;
    logic [31:0] hrdata0;

    int n_pass;
    int n_total;

    scr1_ahb_dmem_sram #(
        .MEM_WORDS  (WORDS),
        .BASE_ADDR  (BASE),
        .WAIT_STATES(1)
    ) u_dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .hsel     (hsel1),
        .htrans   (htrans),
        .haddr    (haddr),
        .hsize    (hsize),
        .hwrite   (hwrite),
        .hwdata   (hwdata),
        .hprot    (hprot),
        .hburst   (hburst),
        .hmastlock(hmastlock),
        .hready   (hready1),
        .hresp    (hresp1),
        .hrdata   (hrdata1)
    );

    scr1_ahb_dmem_sram #(
        .MEM_WORDS  (WORDS),
        .BASE_ADDR  (BASE),
        .WAIT_STATES(0)
    ) u_dut0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .hsel     (hsel0),
        .htrans   (htrans),
        .haddr    (haddr),
        .hsize    (hsize),
        .hwrite   (hwrite),
        .hwdata   (hwdata),
        .hprot    (hprot),
        .hburst   (hburst),
        .hmastlock(hmastlock),
        .hready   (hready0),
        .hresp    (hresp0),
        .hrdata   (hrdata0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        wr;
        logic [2:0]  size;
        logic [31:0] off;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic wr, input logic [2:0] size, input logic [31:0] off,
                                input logic [31:0] wdata, input logic err,
                                input logic [31:0] rdata);
        vec_t v;
        v.wr    = wr;
        v.size  = size;
        v.off   = off;
        v.wdata = wdata;
        v.err   = err;
        v.rdata = rdata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // One isolated transfer on the one-wait-state instance; entered and left at a negedge.
    task automatic xfer(input vec_t v, input int i);
        hsel1  = 1'b1;
        htrans = 2'b10;
        haddr  = BASE + v.off;
        hsize  = v.size;
        hwrite = v.wr;
        @(negedge clk);
        hsel1  = 1'b0;
        htrans = 2'b00;
        hwdata = v.wdata;
        if (v.err) begin
            chk($sformatf("v%0d err1 hready", i), 32'(hready1), 32'd0);
            chk($sformatf("v%0d err1 hresp", i), 32'(hresp1), 32'd1);
            chk($sformatf("v%0d err1 hrdata", i), hrdata1, 32'd0);
            @(negedge clk);
            chk($sformatf("v%0d err2 hready", i), 32'(hready1), 32'd1);
            chk($sformatf("v%0d err2 hresp", i), 32'(hresp1), 32'd1);
            chk($sformatf("v%0d err2 hrdata", i), hrdata1, 32'd0);
        end else begin
            chk($sformatf("v%0d wait hready", i), 32'(hready1), 32'd0);
            chk($sformatf("v%0d wait hresp", i), 32'(hresp1), 32'd0);
            @(negedge clk);
            chk($sformatf("v%0d data hready", i), 32'(hready1), 32'd1);
            chk($sformatf("v%0d data hresp", i), 32'(hresp1), 32'd0);
            if (!v.wr) chk($sformatf("v%0d data hrdata", i), hrdata1, v.rdata);
        end
        @(negedge clk);
        chk($sformatf("v%0d idle hready", i), 32'(hready1), 32'd1);
        chk($sformatf("v%0d idle hresp", i), 32'(hresp1), 32'd0);
        chk($sformatf("v%0d idle hrdata", i), hrdata1, 32'd0);
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        rst_n     = 1'b0;
        hsel0     = 1'b0;
        hsel1     = 1'b0;
        htrans    = 2'b00;
        haddr     = 32'd0;
        hsize     = 3'd0;
        hwrite    = 1'b0;
        hwdata    = 32'd0;
        hprot     = 4'd0;
        hburst    = 3'd0;
        hmastlock = 1'b0;

        //        wr    size  offset          wdata          err   rdata
        vecs.push_back(mk(1'b1, 3'd2, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0));
        vecs.push_back(mk(1'b0, 3'd2, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF));
        vecs.push_back(mk(1'b1, 3'd0, 32'h0000_0020, 32'hFFFF_FF11, 1'b0, 32'h0));
        vecs.push_back(mk(1'b1, 3'd0, 32'h0000_0021, 32'hFFFF_22FF, 1'b0, 32'h0));
        vecs.push_back(mk(1'b1, 3'd0, 32'h0000_0022, 32'hFF33_FFFF, 1'b0, 32'h0));
        vecs.push_back(mk(1'b1, 3'd0, 32'h0000_0023, 32'h44FF_FFFF, 1'b0, 32'h0));
        vecs.push_back(mk(1'b0, 3'd2, 32'h0000_0020, 32'h0,         1'b0, 32'h4433_2211));
        vecs.push_back(mk(1'b1, 3'd1, 32'h0000_0022, 32'hABCD_5555, 1'b0, 32'h0));
        vecs.push_back(mk(1'b0, 3'd2, 32'h0000_0020, 32'h0,         1'b0, 32'hABCD_2211));
        vecs.push_back(mk(1'b1, 3'd1, 32'h0000_0020, 32'h7777_BEEF, 1'b0, 32'h0));
        vecs.push_back(mk(1'b0, 3'd0, 32'h0000_0020, 32'h0,         1'b0, 32'hABCD_BEEF));
        vecs.push_back(mk(1'b1, 3'd2, 32'h0000_00FC, 32'h0BAD_F00D, 1'b0, 32'h0));
        vecs.push_back(mk(1'b0, 3'd2, 32'h0000_0100, 32'h0,         1'b1, 32'h0));
        vecs.push_back(mk(1'b1, 3'd2, 32'hFFFF_FFFC, 32'h1234_5678, 1'b1, 32'h0));
        vecs.push_back(mk(1'b0, 3'd2, 32'h0000_00FC, 32'h0,         1'b0, 32'h0BAD_F00D));
        vecs.push_back(mk(1'b1, 3'd1, 32'h0000_0011, 32'h0,         1'b1, 32'h0));
        vecs.push_back(mk(1'b1, 3'd2, 32'h0000_0012, 32'h0,         1'b1, 32'h0));
        vecs.push_back(mk(1'b1, 3'd3, 32'h0000_0010, 32'h0,         1'b1, 32'h0));
        vecs.push_back(mk(1'b1, 3'd2, 32'h0000_0110, 32'h0,         1'b1, 32'h0));
        vecs.push_back(mk(1'b0, 3'd3, 32'h0000_0000, 32'h0,         1'b1, 32'h0));
        vecs.push_back(mk(1'b0, 3'd2, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF));
        vecs.push_back(mk(1'b0, 3'd1, 32'h0000_0022, 32'h0,         1'b0, 32'hABCD_BEEF));
        vecs.push_back(mk(1'b1, 3'd2, 32'h0000_0040, 32'h1111_1111, 1'b0, 32'h0));

        // Reset state of both instances.
        repeat (2) @(negedge clk);
        chk("rst hready1", 32'(hready1), 32'd1);
        chk("rst hresp1", 32'(hresp1), 32'd0);
        chk("rst hrdata1", hrdata1, 32'd0);
        chk("rst hready0", 32'(hready0), 32'd1);
        chk("rst hresp0", 32'(hresp0), 32'd0);
        chk("rst hrdata0", hrdata0, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) xfer(vecs[i], i);

        // Zero wait states: write then read of the same word back to back.
        hsel0  = 1'b1;
        htrans = 2'b10;
        haddr  = BASE + 32'h30;
        hsize  = 3'd2;
        hwrite = 1'b1;
        @(negedge clk);
        chk("b2b wr data hready0", 32'(hready0), 32'd1);
        chk("b2b wr data hresp0", 32'(hresp0), 32'd0);
        hwdata = 32'hCAFE_F00D;
        hwrite = 1'b0;
        @(negedge clk);
        chk("b2b rd data hready0", 32'(hready0), 32'd1);
        chk("b2b rd data hresp0", 32'(hresp0), 32'd0);
        chk("b2b rd data hrdata0", hrdata0, 32'hCAFE_F00D);
        hsel0  = 1'b0;
        htrans = 2'b00;
        hwdata = 32'h0;
        @(negedge clk);
        chk("b2b idle hready0", 32'(hready0), 32'd1);
        chk("b2b idle hrdata0", hrdata0, 32'd0);

        // Zero wait states still take two cycles for an error.
        hsel0  = 1'b1;
        htrans = 2'b10;
        haddr  = BASE + 32'h1;
        hsize  = 3'd2;
        hwrite = 1'b0;
        @(negedge clk);
        chk("ws0 err1 hready0", 32'(hready0), 32'd0);
        chk("ws0 err1 hresp0", 32'(hresp0), 32'd1);
        hsel0  = 1'b0;
        htrans = 2'b00;
        @(negedge clk);
        chk("ws0 err2 hready0", 32'(hready0), 32'd1);
        chk("ws0 err2 hresp0", 32'(hresp0), 32'd1);
        @(negedge clk);
        chk("ws0 idle hresp0", 32'(hresp0), 32'd0);

        // Reset during the wait phase of a write drops the write.
        hsel1  = 1'b1;
        htrans = 2'b10;
        haddr  = BASE + 32'h40;
        hsize  = 3'd2;
        hwrite = 1'b1;
        @(negedge clk);
        chk("rstmid wait hready1", 32'(hready1), 32'd0);
        hsel1  = 1'b0;
        htrans = 2'b00;
        hwdata = 32'h2222_2222;
        #1 rst_n = 1'b0;
        #1;
        chk("rstmid hready1", 32'(hready1), 32'd1);
        chk("rstmid hresp1", 32'(hresp1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        xfer(mk(1'b0, 3'd2, 32'h0000_0040, 32'h0, 1'b0, 32'h1111_1111), 99);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
